// File: rtl/mipi_csi2_pkg.sv
// Purpose : shared CSI-2 constants: data types, parser state encoding, header ECC parity masks.
// Latency : n/a (declarations only).
// Backpress: n/a.
// Ports   : none.
package mipi_csi2_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_RAW10    = 6'h2B;
   // Data types below this value are short packets (no payload).
   localparam logic [5:0] DT_LONG_MIN = 6'h10;

   typedef enum logic [2:0] {
      IDLE,
      HDR1,
      PAYLOAD,
      CRC,
      DROP
   } state_e;

   // Parity bit k = XOR of header bits selected by ECC_MASK[k];
   // header bit order is {WC_H, WC_L, DI}, DI in [7:0].
   localparam logic [5:0][23:0] ECC_MASK = {
      24'hEFFC00,   // P5
      24'hDF03F0,   // P4
      24'hB8E38E,   // P3
      24'h749A6D,   // P2
      24'hF2555B,   // P1
      24'hF12CB7    // P0
   };

endpackage

// File: rtl/mipi_csi2_packet_parser_if.sv
// Purpose : lane-side input word stream and parsed packet outputs of the CSI-2 parser.
// Latency : n/a (signal bundle).
// Backpress: none; I_Lane_Vaild low marks stall cycles, the parser never stalls its source.
// Ports   : master = lane source / packet sink, slave = parser.
interface mipi_csi2_packet_parser_if;

   logic [15:0] I_Lane_Data;
   logic        I_Lane_Vaild;
   logic        I_Lane_Sof;
   logic [15:0] O_Mipi_Unpacket_Data;
   logic        O_Mipi_Unpacket_Vaild;
   logic        O_Mipi_Sync;
   logic        O_Frame_End;
   logic [1:0]  O_Vc;
   logic        O_Ecc_Err;
   logic        O_Len_Err;

   modport master (
      output I_Lane_Data, I_Lane_Vaild, I_Lane_Sof,
      input  O_Mipi_Unpacket_Data, O_Mipi_Unpacket_Vaild, O_Mipi_Sync,
      input  O_Frame_End, O_Vc, O_Ecc_Err, O_Len_Err
   );

   modport slave (
      input  I_Lane_Data, I_Lane_Vaild, I_Lane_Sof,
      output O_Mipi_Unpacket_Data, O_Mipi_Unpacket_Vaild, O_Mipi_Sync,
      output O_Frame_End, O_Vc, O_Ecc_Err, O_Len_Err
   );

endinterface

// File: rtl/mipi_csi2_ecc.sv
// Purpose : CSI-2 packet header 6-bit Hamming ECC generator.
// Latency : combinational.
// Backpress: none.
// Ports   : data_i = {WC_H, WC_L, DI}, ecc_o = parity bits P5..P0.
module mipi_csi2_ecc
   import mipi_csi2_pkg::*;
(
   input  logic [23:0] data_i,
   output logic [5:0]  ecc_o
);

   always_comb begin
      ecc_o = '0;
      for (int k = 0; k < 6; k++) begin
         ecc_o[k] = ^(data_i & ECC_MASK[k]);
      end
   end

endmodule

// File: rtl/mipi_csi2_packet_parser.sv
// Purpose : CSI-2 2-lane packet parser: header ECC check, FS/FE pulses, RAW payload forwarding.
// Latency : 1 cycle from a valid input word to its registered output/pulse.
// Backpress: none; stall cycles (I_Lane_Vaild=0) freeze the FSM and hold output data.
// Ports   : I_CLK, I_Rst_n (async active-low), csi_bus (slave modport: lane words in, packet outputs).
module mipi_csi2_packet_parser
   import mipi_csi2_pkg::*;
#(
   parameter logic [5:0]  DT_PIXEL = DT_RAW10,
   parameter logic [15:0] MAX_WC   = 16'd4096
) (
   input  logic                       I_CLK,
   input  logic                       I_Rst_n,
   mipi_csi2_packet_parser_if.slave   csi_bus
);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  di_q, di_d;
   logic [7:0]  wcl_q, wcl_d;
   logic [15:0] dat_q, dat_d;
   logic        vld_q, vld_d;
   logic        sync_q, sync_d;
   logic        fe_q, fe_d;
   logic [1:0]  vc_q, vc_d;
   logic        ecc_err_q, ecc_err_d;
   logic        len_err_q, len_err_d;

   logic [15:0] wc;
   logic [5:0]  dt;
   logic [5:0]  ecc_calc;
   logic        wc_ok;

   // Valid only while in HDR1: the current word carries WC_H and the ECC byte.
   assign wc    = {csi_bus.I_Lane_Data[7:0], wcl_q};
   assign dt    = di_q[5:0];
   assign wc_ok = ~wc[0] && (wc != 16'd0) && (wc <= MAX_WC);

   mipi_csi2_ecc u_ecc (
      .data_i ({wc, di_q}),
      .ecc_o  (ecc_calc)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      di_d      = di_q;
      wcl_d     = wcl_q;
      dat_d     = dat_q;
      vld_d     = 1'b0;
      sync_d    = 1'b0;
      fe_d      = 1'b0;
      vc_d      = vc_q;
      ecc_err_d = 1'b0;
      len_err_d = 1'b0;

      if (csi_bus.I_Lane_Vaild) begin
         if (csi_bus.I_Lane_Sof) begin
            // Start of burst wins in every state: abandon whatever was in flight.
            di_d    = csi_bus.I_Lane_Data[7:0];
            wcl_d   = csi_bus.I_Lane_Data[15:8];
            state_d = HDR1;
         end else begin
            case (state_q)
               HDR1: begin
                  // Bits [7:6] of the ECC byte are not part of the code and are ignored.
                  if (csi_bus.I_Lane_Data[13:8] != ecc_calc) begin
                     ecc_err_d = 1'b1;
                     state_d   = DROP;
                  end else begin
                     vc_d = di_q[7:6];
                     if (dt < DT_LONG_MIN) begin
                        sync_d  = (dt == DT_FS);
                        fe_d    = (dt == DT_FE);
                        state_d = IDLE;
                     end else if (dt != DT_PIXEL) begin
                        state_d = DROP;
                     end else if (wc_ok) begin
                        cnt_d   = {1'b0, wc[15:1]};
                        state_d = PAYLOAD;
                     end else begin
                        len_err_d = 1'b1;
                        state_d   = DROP;
                     end
                  end
               end
               PAYLOAD: begin
                  dat_d = csi_bus.I_Lane_Data;
                  vld_d = 1'b1;
                  cnt_d = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     state_d = CRC;
                  end
               end
               CRC:     state_d = IDLE;
               default: state_d = state_q;   // IDLE and DROP discard non-Sof words
            endcase
         end
      end
   end

   always_ff @(posedge I_CLK or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         di_q      <= '0;
         wcl_q     <= '0;
         dat_q     <= '0;
         vld_q     <= 1'b0;
         sync_q    <= 1'b0;
         fe_q      <= 1'b0;
         vc_q      <= '0;
         ecc_err_q <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         di_q      <= di_d;
         wcl_q     <= wcl_d;
         dat_q     <= dat_d;
         vld_q     <= vld_d;
         sync_q    <= sync_d;
         fe_q      <= fe_d;
         vc_q      <= vc_d;
         ecc_err_q <= ecc_err_d;
         len_err_q <= len_err_d;
      end
   end

   assign csi_bus.O_Mipi_Unpacket_Data  = dat_q;
   assign csi_bus.O_Mipi_Unpacket_Vaild = vld_q;
   assign csi_bus.O_Mipi_Sync           = sync_q;
   assign csi_bus.O_Frame_End           = fe_q;
   assign csi_bus.O_Vc                  = vc_q;
   assign csi_bus.O_Ecc_Err             = ecc_err_q;
   assign csi_bus.O_Len_Err             = len_err_q;

endmodule

// File: tb/tb_mipi_csi2_packet_parser.sv
// Purpose : self-checking bench for mipi_csi2_packet_parser (vector table + expectation queue).
// Latency : each table row's expected outputs are compared one clock after the row is driven.
// Backpress: stall rows drive I_Lane_Vaild=0 with junk data and stray Sof.
module tb_mipi_csi2_packet_parser;

   typedef struct {
      logic        vld;
      logic        sof;
      logic [15:0] dat;
      logic        e_vld;
      logic [15:0] e_dat;
      logic        e_sync;
      logic        e_fe;
      logic        e_ecc;
      logic        e_len;
      logic [1:0]  e_vc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mipi_csi2_packet_parser_if bus ();

   mipi_csi2_packet_parser #(
      .DT_PIXEL (6'h2B),
      .MAX_WC   (16'd4096)
   ) dut (
      .I_CLK   (clk),
      .I_Rst_n (rst_n),
      .csi_bus (bus)
   );

   vec_t        tbl[$];
   vec_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_dat = 16'h0000;
   logic [1:0]  exp_vc  = 2'b00;

   // Reference CSI-2 header ECC, written out term by term.
   function automatic logic [5:0] ecc6(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   function automatic logic [22:0] obs();
      return {bus.O_Mipi_Unpacket_Vaild, bus.O_Mipi_Unpacket_Data, bus.O_Mipi_Sync,
              bus.O_Frame_End, bus.O_Ecc_Err, bus.O_Len_Err, bus.O_Vc};
   endfunction

   task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (vld,dat,sync,fe,ecc,len,vc)", nm, got, want);
      end
   endtask

   // One table row; the expected data output holds its last forwarded value.
   task automatic add(input logic vld, input logic sof, input logic [15:0] dat,
                      input logic ev, input logic es, input logic ef,
                      input logic ee, input logic el);
      vec_t r;
      if (ev) exp_dat = dat;
      r.vld = vld; r.sof = sof; r.dat = dat;
      r.e_vld = ev; r.e_dat = exp_dat; r.e_sync = es; r.e_fe = ef;
      r.e_ecc = ee; r.e_len = el; r.e_vc = exp_vc;
      tbl.push_back(r);
   endtask

   task automatic add_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [5:0] flip,
                          input logic stl, input logic es, input logic ef,
                          input logic ee, input logic el);
      logic [7:0] ecc;
      ecc = {2'b00, ecc6({wc, di}) ^ flip};
      add(1'b1, 1'b1, {wc[7:0], di}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (stl) add(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!ee) exp_vc = di[7:6];
      add(1'b1, 1'b0, {ecc, wc[15:8]}, 1'b0, es, ef, ee, el);
      if (stl) add(1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Words first..last of the 0x0201, 0x0403, ... payload pattern.
   task automatic add_pl(input int first, input int last, input logic fwd, input logic stl);
      for (int k = first; k <= last; k++) begin
         logic [7:0] hi;
         logic [7:0] lo;
         hi = 8'(2 * k);
         lo = 8'(2 * k - 1);
         add(1'b1, 1'b0, {hi, lo}, fwd, 1'b0, 1'b0, 1'b0, 1'b0);
         if (stl) add(1'b0, k[0], 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic idle_word(input logic [15:0] d);
      add(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_tbl(input string nm);
      vec_t v;
      vec_t e;
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         bus.I_Lane_Vaild = v.vld;
         bus.I_Lane_Sof   = v.sof;
         bus.I_Lane_Data  = v.dat;
         sb.push_back(v);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("%s[%0d]", nm, i), obs(),
             {e.e_vld, e.e_dat, e.e_sync, e.e_fe, e.e_ecc, e.e_len, e.e_vc});
      end
      tbl.delete();
      @(negedge clk);
      bus.I_Lane_Vaild = 1'b0;
      bus.I_Lane_Sof   = 1'b0;
   endtask

   initial begin
      bus.I_Lane_Data  = 16'h0000;
      bus.I_Lane_Vaild = 1'b0;
      bus.I_Lane_Sof   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", obs(), 23'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle junk and a stalled Sof are both ignored.
      idle_word(16'hFFFF);
      add(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Frame Start, then Frame End on VC1.
      add_hdr(8'h00, 16'h0001, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add_hdr(8'h41, 16'h0000, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // RAW10 WC=10: five words forwarded, CRC word dropped.
      add_hdr(8'h2B, 16'd10, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_pl(1, 5, 1'b1, 1'b0);
      idle_word(16'hC3C3);
      idle_word(16'h5555);
      // Same packet with a stall after every word.
      add_hdr(8'h2B, 16'd10, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add_pl(1, 5, 1'b1, 1'b1);
      idle_word(16'hC3C3);
      add(1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_word(16'h5555);
      // ECC bit 0 flipped: error pulse, payload dropped, next FS accepted.
      add_hdr(8'h6B, 16'd10, 6'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add_pl(1, 5, 1'b0, 1'b0);
      idle_word(16'hC3C3);
      add_hdr(8'h00, 16'h0001, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      // Length rejections: odd, zero, above maximum.
      add_hdr(8'h2B, 16'd9, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add_pl(1, 2, 1'b0, 1'b0);
      add_hdr(8'h6B, 16'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add_hdr(8'h2B, 16'd4098, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add_pl(1, 3, 1'b0, 1'b0);
      // Other long data type: dropped silently.
      add_hdr(8'h2A, 16'd10, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_pl(1, 5, 1'b0, 1'b0);
      idle_word(16'hC3C3);
      // Short packet that is neither FS nor FE: no pulse, back to idle.
      add_hdr(8'h88, 16'h1234, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_word(16'h7777);
      // Largest accepted length on VC3: exactly 2048 words forwarded.
      add_hdr(8'hEB, 16'd4096, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2048; k++) begin
         logic [15:0] w;
         w = 16'(k) ^ 16'hA5A5;
         add(1'b1, 1'b0, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      idle_word(16'hC3C3);
      idle_word(16'h5555);
      // Sof at the 3rd payload word aborts and starts a new FS header.
      add_hdr(8'h2B, 16'd10, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_pl(1, 2, 1'b1, 1'b0);
      add_hdr(8'h00, 16'h0001, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add_pl(4, 5, 1'b0, 1'b0);
      run_tbl("main");

      // Reset asserted during the 3rd payload word of a VC3 packet.
      add_hdr(8'hEB, 16'd10, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_pl(1, 2, 1'b1, 1'b0);
      run_tbl("pre_rst");
      bus.I_Lane_Vaild = 1'b1;
      bus.I_Lane_Data  = 16'h0605;
      rst_n = 1'b0;
      #1;
      chk("rst_async", obs(), 23'h0);
      @(posedge clk);
      #1;
      chk("rst_hold", obs(), 23'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.I_Lane_Vaild = 1'b0;
      exp_dat = 16'h0000;
      exp_vc  = 2'b00;
      add_pl(3, 5, 1'b0, 1'b0);
      idle_word(16'hC3C3);
      add_hdr(8'h00, 16'h0001, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add_pl(1, 2, 1'b0, 1'b0);
      run_tbl("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mipi_csi2_packet_parser.md
MIPI_CSI2_PACKET_PARSER -- requirements
Module: mipi_csi2_packet_parser

Interface
REQ-001 SHALL have parameter DT_PIXEL, default 6'h2B, the data type whose long-packet payload is forwarded (RAW10).
REQ-002 SHALL have parameter MAX_WC, default 16'd4096, the largest accepted payload byte count.
REQ-003 SHALL have I_CLK  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have I_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have I_Lane_Data  input  16  merged 2-lane byte pair: [7:0] is the earlier byte, [15:8] the later byte.
REQ-006 SHALL have I_Lane_Vaild  input  1  I_Lane_Data qualifier; low cycles are stalls.
REQ-007 SHALL have I_Lane_Sof  input  1  marks the first valid word of an HS burst; sampled only with I_Lane_Vaild=1.
REQ-008 SHALL have O_Mipi_Unpacket_Data  output  16  payload byte pair, same byte order as input.
REQ-009 SHALL have O_Mipi_Unpacket_Vaild  output  1  payload qualifier.
REQ-010 SHALL have O_Mipi_Sync  output  1  one-cycle pulse on an accepted Frame Start short packet.
REQ-011 SHALL have O_Frame_End  output  1  one-cycle pulse on an accepted Frame End short packet.
REQ-012 SHALL have O_Vc  output  2  virtual channel of the last accepted header.
REQ-013 SHALL have O_Ecc_Err  output  1  one-cycle pulse when a header ECC mismatch is detected.
REQ-014 SHALL have O_Len_Err  output  1  one-cycle pulse on a long packet that is rejected for length.

Function
REQ-015 SHALL implement FSM states IDLE, HDR1, PAYLOAD, CRC, DROP; a state advances only on cycles with I_Lane_Vaild=1.
REQ-016 IDLE SHALL take a word qualified by I_Lane_Sof as header word 0, latch DI=[7:0] and WC[7:0]=[15:8], then go to HDR1.
REQ-017 HDR1 SHALL latch WC[15:8]=[7:0] and ECC=[15:8], and check ECC = the CSI-2 6-bit Hamming code over {WC_H, WC_L, DI}; correction is not supported.
REQ-018 On ECC mismatch SHALL pulse O_Ecc_Err and go to DROP.
REQ-019 Short packet (DT<6'h10) SHALL go to IDLE and emit no payload; DT 6'h00 pulses O_Mipi_Sync, DT 6'h01 pulses O_Frame_End, one cycle after the HDR1 word.
REQ-020 Long packet with DT=DT_PIXEL, WC even, and 0<WC<=MAX_WC SHALL go to PAYLOAD; a down-counter is loaded with WC/2.
REQ-021 Long packet violating REQ-020 on WC SHALL pulse O_Len_Err and go to DROP; any other long DT SHALL go to DROP silently.
REQ-022 PAYLOAD SHALL forward each valid word as O_Mipi_Unpacket_Data with O_Mipi_Unpacket_Vaild=1, registered, latency 1 cycle, and decrement the counter.
REQ-023 PAYLOAD SHALL go to CRC when the last word is forwarded (counter 1->0).
REQ-024 CRC SHALL discard the next valid word (CRC is not checked) and go to IDLE.
REQ-025 DROP SHALL discard words until I_Lane_Sof; words in IDLE without I_Lane_Sof are discarded.
REQ-026 I_Lane_Sof in any state other than IDLE SHALL abort the current packet without a pulse; that word is processed as header word 0 (HDR1 next).
REQ-027 O_Mipi_Unpacket_Vaild SHALL be 0 on all cycles except those of REQ-022; stall cycles produce Vaild=0 and hold the data.
REQ-028 O_Vc SHALL update to DI[7:6] on every ECC-correct header.

Reset
REQ-029 I_Rst_n low SHALL asynchronously force state IDLE, counter 0, all outputs 0 (data 16'h0000, O_Vc 2'b00).
REQ-030 Reset mid-packet SHALL discard the packet; after release, nothing is forwarded until the next I_Lane_Sof.

Structure
REQ-031 Shared package mipi_csi2_pkg SHALL hold DT constants (FS 6'h00, FE 6'h01, RAW10 6'h2B), the state enum, and the ECC parity-matrix constants.
REQ-032 ECC generation SHALL be a combinational sub-module mipi_csi2_ecc (24-bit in, 6-bit out), shared with future TX/test blocks.

Verification
REQ-033 FS header DI=0x00, WC=0x0001, correct ECC -> single O_Mipi_Sync pulse, O_Vc=0, no Vaild.
REQ-034 RAW10 packet DI=0x2B, WC=10, payload words 0x0201..0x0A09, then CRC -> exactly 5 Vaild cycles with identical data, each 1 cycle after its input; CRC word is not forwarded.
REQ-035 The REQ-034 packet with I_Lane_Vaild low on alternate cycles -> same 5 words, Vaild only on the cycles following valid inputs.
REQ-036 Header with ECC bit 0 flipped -> O_Ecc_Err pulse, payload dropped; the next FS is accepted.
REQ-037 DI=0x2B with WC=9 -> O_Len_Err pulse, no Vaild; DI=0x2A with WC=10 -> no Vaild, no error.
REQ-038 I_Lane_Sof at the 3rd payload word, and separately reset at the 3rd payload word -> Sof case: the old packet aborts and the new header is parsed; reset case: outputs are 0 and nothing is forwarded until the next Sof.
